// File: rtl/stream_mux_rr_pkg.sv
// Shared constants and helpers for the round-robin stream multiplexer.
// Optional output register stage: STREAM_MUX_RR_OUT_REG_EN.
package stream_mux_rr_pkg;

  localparam int N_CH_DEF  = 4;
  localparam int WIDTH_DEF = 8;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from ptr upward with wrap.
// ptr moves past the channel that actually transferred on adv.
module rr_arbiter
  import stream_mux_rr_pkg::*;
#(
  parameter int N_CH = N_CH_DEF,
  parameter int PW   = ch_w(N_CH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] req,
  input  logic            adv,
  input  logic [PW-1:0]   adv_ch,
  output logic [N_CH-1:0] grant,
  output logic [PW-1:0]   gidx,
  output logic            any
);

  logic [PW-1:0] ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (adv) begin
      if (adv_ch == PW'(N_CH - 1))
        ptr <= '0;
      else
        ptr <= adv_ch + PW'(1);
    end
  end

  // First pass covers ptr..N_CH-1, second pass the wrapped range.
  always_comb begin
    grant = '0;
    gidx  = '0;
    any   = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (!any && req[i] && (PW'(i) >= ptr)) begin
        any      = 1'b1;
        grant[i] = 1'b1;
        gidx     = PW'(i);
      end
    end
    for (int i = 0; i < N_CH; i++) begin
      if (!any && req[i]) begin
        any      = 1'b1;
        grant[i] = 1'b1;
        gidx     = PW'(i);
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-to-1 valid/ready stream multiplexer with round-robin arbitration.
// STREAM_MUX_RR_OUT_REG_EN selects a registered output stage.
module stream_mux_rr
  import stream_mux_rr_pkg::*;
#(
  parameter  int N_CH  = N_CH_DEF,
  parameter  int WIDTH = WIDTH_DEF,
  localparam int PW    = ch_w(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH*WIDTH-1:0] in_data,
  output logic [N_CH-1:0]       in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [PW-1:0]         out_ch,
  input  logic                  out_ready
);

  logic [N_CH-1:0]  grant;
  logic [PW-1:0]    gidx;
  logic             any;
  logic [N_CH-1:0]  sel_oh;
  logic [PW-1:0]    sel_ch;
  logic [WIDTH-1:0] mux_d;
  logic             adv;

  rr_arbiter #(
    .N_CH (N_CH),
    .PW   (PW)
  ) u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (in_valid),
    .adv    (adv),
    .adv_ch (sel_ch),
    .grant  (grant),
    .gidx   (gidx),
    .any    (any)
  );

  always_comb begin
    mux_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (sel_ch == PW'(i))
        mux_d = in_data[i*WIDTH +: WIDTH];
    end
  end

`ifdef STREAM_MUX_RR_OUT_REG_EN

  logic             ov_q;
  logic [WIDTH-1:0] od_q;
  logic [PW-1:0]    oc_q;
  logic             take;

  assign sel_oh = grant;
  assign sel_ch = gidx;
  assign take   = rst_n & any & (~ov_q | out_ready);
  assign adv    = take;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ov_q <= 1'b0;
      od_q <= '0;
      oc_q <= '0;
    end else if (take) begin
      ov_q <= 1'b1;
      od_q <= mux_d;
      oc_q <= sel_ch;
    end else if (out_ready) begin
      ov_q <= 1'b0;
    end
  end

  assign in_ready  = sel_oh & {N_CH{take}};
  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign out_ch    = oc_q;

`else

  logic            lock_q;
  logic [N_CH-1:0] lock_oh;
  logic [PW-1:0]   lock_ch;
  logic            sel_vld;

  // A stalled output freezes the selection until it is consumed.
  assign sel_vld = rst_n & (lock_q | any);
  assign sel_oh  = lock_q ? lock_oh : grant;
  assign sel_ch  = lock_q ? lock_ch : gidx;
  assign adv     = sel_vld & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q  <= 1'b0;
      lock_oh <= '0;
      lock_ch <= '0;
    end else begin
      lock_q  <= sel_vld & ~out_ready;
      lock_oh <= sel_oh;
      lock_ch <= sel_ch;
    end
  end

  assign in_ready  = sel_oh & {N_CH{adv}};
  assign out_valid = sel_vld;
  assign out_data  = sel_vld ? mux_d : '0;
  assign out_ch    = sel_vld ? sel_ch : '0;

`endif

endmodule

// File: doc/stream_mux_rr.md
STREAM_MUX_RR -- requirements
Module: stream_mux_rr

Interface
REQ-001 Parameter N_CH, default 4, number of input channels, legal range 1..16.
REQ-002 Parameter WIDTH, default 8, data bits per channel, legal range 1..64.
REQ-003 Clocking: one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  N_CH  per-channel data-valid.
REQ-007 in_data  input  N_CH x WIDTH  per-channel payload, channel i in slice i.
REQ-008 in_ready  output  N_CH  per-channel accept; at most one bit set per cycle.
REQ-009 out_valid  output  1  output payload valid.
REQ-010 out_data  output  WIDTH  selected payload.
REQ-011 out_ch  output  max(1,$clog2(N_CH))  index of the channel carried on out_data.
REQ-012 out_ready  input  1  downstream accept.

Function
REQ-013 Transfer occurs on an input when in_valid[i] and in_ready[i] are both high at a clk edge; on the output when out_valid and out_ready are both high.
REQ-014 Arbiter holds a round-robin pointer ptr (0..N_CH-1); grant = first i with in_valid[i] high, searching ptr, ptr+1, ..., wrapping N_CH-1 -> 0.
REQ-015 After every accepted input transfer from channel g, ptr SHALL become g+1, or 0 when g = N_CH-1.
REQ-016 With no in_valid high: out_valid SHALL be low (path permitting), all in_ready low, ptr unchanged.
REQ-017 Once out_valid is high and out_ready low, out_data, out_ch and out_valid SHALL hold stable until the output transfer, even if higher-priority channels assert in_valid.
REQ-018 A locked source dropping in_valid before its transfer is a protocol violation; the block need not handle it.
REQ-019 Sustained throughput SHALL be one transfer per cycle while any in_valid and out_ready are high.
REQ-020 With all N_CH channels continuously valid, grants SHALL rotate 0,1,...,N_CH-1,0,...; no channel waits more than N_CH-1 transfers.
REQ-021 N_CH = 1: ptr is constant 0; block acts as a pass-through (or single register stage, REQ-026).

Reset
REQ-022 While rst_n is low: out_valid = 0, in_ready = 0, out_ch = 0, out_data = 0, ptr = 0, lock cleared.
REQ-023 Reset asserted mid-transfer SHALL discard the held payload; no output transfer completes on the reset edge.
REQ-024 First grant after rst_n deassertion SHALL search from channel 0.

Configuration
REQ-025 Macro STREAM_MUX_RR_OUT_REG_EN undefined: combinational data path; out_valid = OR of in_valid (or lock); in_ready[g] = grant[g] & out_ready; latency 0; lock register holds grant while out_valid & !out_ready.
REQ-026 Macro STREAM_MUX_RR_OUT_REG_EN defined: out_valid/out_data/out_ch registered; in_ready[g] = grant[g] & (!out_valid | out_ready); latency 1 cycle; REQ-019 throughput retained; no combinational path from in_* to out_* or from out_ready to out_*.

Structure
REQ-027 Package stream_mux_rr_pkg SHALL hold default N_CH/WIDTH constants and a function computing the out_ch width.
REQ-028 Sub-module rr_arbiter (N_CH request in, one-hot grant out, advance strobe, ptr state) SHALL hold all arbitration state; stream_mux_rr instantiates it once and holds only the data path and lock/output register.

Verification
REQ-029 N_CH=4, WIDTH=8, in_valid=4'b1111, data i=8'hA0+i, out_ready=1 for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3, out_data A0,A1,A2,A3,... .
REQ-030 in_valid=4'b0100, out_ready=0 for 3 cycles, then in_valid=4'b0101 -> out_ch stays 2, out_data stays A2 until out_ready=1; next grant goes to channel 0.
REQ-031 ptr=3 (after channel 2 transfer), in_valid=4'b1001 -> grant channel 3, then channel 0 (wrap).
REQ-032 Only channel 1 valid for 5 cycles with out_ready=1 -> 5 back-to-back transfers from channel 1, in_ready=4'b0010 each cycle.
REQ-033 Assert rst_n=0 while out_valid=1, out_ready=0 -> out_valid=0, in_ready=0 immediately; after release with in_valid=4'b1010 first grant is channel 1.
REQ-034 Run REQ-029..REQ-033 with and without STREAM_MUX_RR_OUT_REG_EN, and with N_CH=1, WIDTH=1: payload order identical, registered build lagging exactly 1 cycle.
